// File: rtl/node_eval_datapath.sv
// Feature double-buffer, bias + sum(coeff*feature) accumulator and result register
// closing the decision loop of the tree-walk control block.
module node_eval_datapath #(
    parameter int FEATURES          = 3,
    parameter int COEFF_BIT_DEPTH   = 4,
    parameter int BIAS_BIT_DEPTH    = 10,
    parameter int FEATURE_BIT_DEPTH = 8,
    parameter int ACC_WIDTH         = 16
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [FEATURES*FEATURE_BIT_DEPTH-1:0]  in_features,
    output logic                                   next,
    input  logic                                   load_bias,
    input  logic                                   add,
    input  logic                                   mult,
    input  logic                                   is_one,
    input  logic [COEFF_BIT_DEPTH-1:0]             coeff,
    input  logic [BIAS_BIT_DEPTH-1:0]              bias,
    output logic                                   child_direction,
    input  logic [$clog2(FEATURES)-1:0]            ctl_level,
    input  logic [$clog2(FEATURES)-1:0]            ctl_path,
    input  logic                                   ctl_out_valid,
    output logic                                   cls_valid,
    output logic [$clog2(FEATURES)-1:0]            cls_level,
    output logic [$clog2(FEATURES)-1:0]            cls_path,
    output logic                                   protocol_err
);
    localparam int IDX_W  = $clog2(FEATURES);
    localparam int FW     = FEATURE_BIT_DEPTH;
    localparam int PROD_W = COEFF_BIT_DEPTH + FEATURE_BIT_DEPTH;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FEATURES - 1);

    logic [FEATURES*FW-1:0] active_feat, pending_feat;
    logic                   active_full, pending_full, moved, dir_q;
    logic [IDX_W-1:0]       feat_idx, cur_idx, idx_next;
    logic [ACC_WIDTH-1:0]   acc, acc_next, term, bias_ext;
    logic [FW-1:0]          cur_feat;
    logic signed [PROD_W-1:0] product;
    logic                   accept, move, last_term;

    always_comb begin
        in_ready = ~pending_full;
        accept   = in_valid & ~pending_full;
        move     = ~active_full & pending_full;
        // A load_bias cycle always evaluates feature 0, whatever feat_idx holds.
        cur_idx  = load_bias ? '0 : feat_idx;
        cur_feat = '0;
        for (int i = 0; i < FEATURES; i++) begin
            if (cur_idx == IDX_W'(i))
                cur_feat = active_feat[(FEATURES-1-i)*FW +: FW];
        end
        product  = PROD_W'($signed(coeff)) * PROD_W'($signed(cur_feat));
        term     = '0;
        if (active_full) begin
            if (is_one)
                term = {{(ACC_WIDTH-FW){cur_feat[FW-1]}}, cur_feat};
            else if (mult)
                term = {{(ACC_WIDTH-PROD_W){product[PROD_W-1]}}, product};
        end
        bias_ext = {{(ACC_WIDTH-BIAS_BIT_DEPTH){bias[BIAS_BIT_DEPTH-1]}}, bias};
        acc_next = acc;
        if (add)
            acc_next = (load_bias ? bias_ext : acc) + term;
        idx_next  = (cur_idx == LAST_IDX) ? LAST_IDX : cur_idx + 1'b1;
        last_term = add && (cur_idx == LAST_IDX);
        // Decision is visible in the cycle of the final term, then held.
        child_direction = last_term ? ~acc_next[ACC_WIDTH-1] : dir_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            active_feat  <= '0;
            pending_feat <= '0;
            active_full  <= 1'b0;
            pending_full <= 1'b0;
            moved        <= 1'b0;
            next         <= 1'b0;
            acc          <= '0;
            feat_idx     <= '0;
            dir_q        <= 1'b0;
            cls_valid    <= 1'b0;
            cls_level    <= '0;
            cls_path     <= '0;
            protocol_err <= 1'b0;
        end else begin
            if (accept) begin
                pending_feat <= in_features;
                pending_full <= 1'b1;
            end else if (move) begin
                pending_full <= 1'b0;
            end
            if (move) begin
                active_feat <= pending_feat;
                active_full <= 1'b1;
            end else if (ctl_out_valid) begin
                active_full <= 1'b0;
            end
            moved <= move;
            next  <= moved;
            acc   <= acc_next;
            if (add)
                feat_idx <= idx_next;
            if (last_term)
                dir_q <= ~acc_next[ACC_WIDTH-1];
            cls_valid <= ctl_out_valid;
            if (ctl_out_valid) begin
                cls_level <= ctl_level;
                cls_path  <= ctl_path;
            end
            if ((add || ctl_out_valid) && !active_full)
                protocol_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_node_eval_datapath.sv
// Directed bench for node_eval_datapath: buffering, accumulation, completion,
// asynchronous reset and protocol error behaviour.
module tb_node_eval_datapath;
    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] in_features;
    logic        next;
    logic        load_bias, add, mult, is_one;
    logic [3:0]  coeff;
    logic [9:0]  bias;
    logic        child_direction;
    logic [1:0]  ctl_level, ctl_path;
    logic        ctl_out_valid;
    logic        cls_valid;
    logic [1:0]  cls_level, cls_path;
    logic        protocol_err;

    int checks = 0;
    int errors = 0;

    node_eval_datapath dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_features(in_features), .next(next), .load_bias(load_bias), .add(add),
        .mult(mult), .is_one(is_one), .coeff(coeff), .bias(bias),
        .child_direction(child_direction), .ctl_level(ctl_level), .ctl_path(ctl_path),
        .ctl_out_valid(ctl_out_valid), .cls_valid(cls_valid), .cls_level(cls_level),
        .cls_path(cls_path), .protocol_err(protocol_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [23:0] pack(input int f0, input int f1, input int f2);
        logic [7:0] a, b, c;
        a = 8'(f0); b = 8'(f1); c = 8'(f2);
        return {a, b, c};
    endfunction

    task automatic idle_ctl();
        load_bias = 0; add = 0; mult = 0; is_one = 0; coeff = '0; bias = '0;
        ctl_out_valid = 0; ctl_level = '0; ctl_path = '0;
    endtask

    // Offer one vector into an empty datapath and follow it to the next pulse.
    task automatic load_vec(input logic [23:0] f);
        in_valid = 1; in_features = f;
        #1; checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL load_ready got=%b exp=1", in_ready); end
        step(); in_valid = 0;
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (next !== (c == 2)) begin
                errors++; $display("FAIL load_next c%0d got=%b exp=%b", c, next, (c == 2));
            end
            if (c < 3) step();
        end
    endtask

    task automatic test_reset();
        reset = 0; in_valid = 0; in_features = '0; idle_ctl();
        #3; checks++;
        if ({next, cls_valid, cls_level, cls_path, protocol_err, child_direction} !== 8'b0) begin
            errors++; $display("FAIL reset_outs got=%b exp=0", {next, cls_valid, cls_level, cls_path, protocol_err, child_direction});
        end
        step(); step(); reset = 1; step();
        checks++;
        if (in_ready !== 1'b1 || dut.acc !== 16'd0) begin
            errors++; $display("FAIL reset_release in_ready=%b acc=%0d exp 1/0", in_ready, dut.acc);
        end
    endtask

    task automatic test_eval();
        int f[3][3]   = '{'{10, -3, 5}, '{10, -3, 5}, '{4, 0, 0}};
        int bs[3]     = '{-20, 20, -4};
        int one_t[3][3] = '{'{1, 0, 0}, '{1, 0, 0}, '{1, 0, 0}};
        int mul_t[3][3] = '{'{0, 1, 1}, '{0, 1, 1}, '{1, 0, 0}};
        int cf[3][3]  = '{'{0, 2, -1}, '{0, 2, -1}, '{7, 3, 5}};
        int ea[3][3]  = '{'{-10, -16, -21}, '{30, 24, 19}, '{0, 0, 0}};
        logic ed[3]   = '{1'b0, 1'b1, 1'b1};
        logic prev[3] = '{1'b0, 1'b0, 1'b1};
        for (int k = 0; k < 3; k++) begin
            load_vec(pack(f[k][0], f[k][1], f[k][2]));
            for (int t = 0; t < 3; t++) begin
                add = 1; load_bias = (t == 0); bias = 10'(bs[k]);
                is_one = one_t[k][t][0]; mult = mul_t[k][t][0]; coeff = 4'(cf[k][t]);
                #1; checks++;
                if (child_direction !== ((t == 2) ? ed[k] : prev[k])) begin
                    errors++; $display("FAIL eval%0d_dir t%0d got=%b exp=%b", k, t, child_direction, (t == 2) ? ed[k] : prev[k]);
                end
                step(); checks++;
                if (dut.acc !== 16'(ea[k][t])) begin
                    errors++; $display("FAIL eval%0d_acc t%0d got=%0d exp=%0d", k, t, $signed(dut.acc), ea[k][t]);
                end
            end
            idle_ctl(); step(); checks++;
            if (child_direction !== ed[k]) begin
                errors++; $display("FAIL eval%0d_hold got=%b exp=%b", k, child_direction, ed[k]);
            end
            ctl_out_valid = 1; ctl_level = 2'(k); ctl_path = 2'(k);
            step(); ctl_out_valid = 0; checks++;
            if (cls_valid !== 1'b1 || cls_level !== 2'(k)) begin
                errors++; $display("FAIL eval%0d_cls got=%b/%0d exp=1/%0d", k, cls_valid, cls_level, k);
            end
            step();
        end
    endtask

    task automatic test_complete();
        load_vec(pack(1, 2, 3));
        ctl_out_valid = 1; ctl_level = 2'd2; ctl_path = 2'b10;
        #1; checks++;
        if (cls_valid !== 1'b0) begin errors++; $display("FAIL cmp_early got=%b exp=0", cls_valid); end
        step(); ctl_out_valid = 0; ctl_level = '0; ctl_path = '0;
        checks++;
        if (cls_valid !== 1'b1 || cls_level !== 2'd2 || cls_path !== 2'b10 || dut.active_full !== 1'b0) begin
            errors++; $display("FAIL cmp_result got=%b/%0d/%b/%b exp=1/2/10/0", cls_valid, cls_level, cls_path, dut.active_full);
        end
        step(); checks++;
        if (cls_valid !== 1'b0 || cls_level !== 2'd2 || protocol_err !== 1'b0) begin
            errors++; $display("FAIL cmp_after got=%b/%0d err=%b exp=0/2/0", cls_valid, cls_level, protocol_err);
        end
    endtask

    task automatic test_back_to_back();
        logic [23:0] v[3];
        logic [12:0] exp_ready = 13'b1111000100010; // bit c = cycle c
        logic [12:0] exp_next  = 13'b0010001000100;
        logic [12:0] exp_cls   = 13'b1000100010000;
        int vi = 0;
        logic take;
        v[0] = pack(11, -1, 2); v[1] = pack(-7, 8, 9); v[2] = pack(3, -4, 127);
        in_valid = 1; in_features = v[0];
        step(); vi = 1; in_features = v[1];
        for (int c = 0; c <= 12; c++) begin
            checks++;
            if (in_ready !== exp_ready[c] || next !== exp_next[c] || cls_valid !== exp_cls[c]) begin
                errors++; $display("FAIL b2b_c%0d got rdy/next/cls=%b%b%b exp=%b%b%b", c, in_ready, next, cls_valid, exp_ready[c], exp_next[c], exp_cls[c]);
            end
            if (exp_next[c]) begin
                checks++;
                if (dut.active_feat !== v[c/4]) begin
                    errors++; $display("FAIL b2b_order c%0d got=%h exp=%h", c, dut.active_feat, v[c/4]);
                end
            end
            ctl_out_valid = (c == 3 || c == 7 || c == 11);
            take = in_valid & in_ready;
            step();
            if (take) vi++;
            in_valid = (vi < 3);
            if (vi < 3) in_features = v[vi];
        end
        idle_ctl(); in_valid = 0;
    endtask

    task automatic test_reset_mid();
        load_vec(pack(10, -3, 5));
        add = 1; load_bias = 1; is_one = 1; bias = 10'd100;
        step(); load_bias = 0; is_one = 0; mult = 1; coeff = 4'd2;
        step(); idle_ctl();
        #1 reset = 0;
        #1; checks++;
        if ({next, cls_valid, child_direction, protocol_err} !== 4'b0 || dut.acc !== 16'd0 || dut.active_full !== 1'b0) begin
            errors++; $display("FAIL rmid_async got=%b acc=%0d act=%b exp=0", {next, cls_valid, child_direction, protocol_err}, dut.acc, dut.active_full);
        end
        step(); reset = 1;
        for (int c = 0; c < 5; c++) begin
            step(); checks++;
            if (cls_valid !== 1'b0 || in_ready !== 1'b1 || next !== 1'b0) begin
                errors++; $display("FAIL rmid_post c%0d got cls/rdy/next=%b%b%b exp=010", c, cls_valid, in_ready, next);
            end
        end
    endtask

    task automatic test_protocol_err();
        checks++;
        if (protocol_err !== 1'b0) begin errors++; $display("FAIL perr_pre got=%b exp=0", protocol_err); end
        add = 1; load_bias = 1; is_one = 1; bias = 10'd37;
        step(); idle_ctl(); checks++;
        if (protocol_err !== 1'b1 || dut.acc !== 16'd37) begin
            errors++; $display("FAIL perr_add got err=%b acc=%0d exp=1/37", protocol_err, dut.acc);
        end
        step(); step(); checks++;
        if (protocol_err !== 1'b1) begin errors++; $display("FAIL perr_sticky got=%b exp=1", protocol_err); end
    endtask

    initial begin
        test_reset();
        test_eval();
        test_complete();
        test_back_to_back();
        test_reset_mid();
        test_protocol_err();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/node_eval_datapath.md
Name: node_eval_datapath

Overview:
- Arithmetic and feature-buffering stage that sits directly downstream of the tree-walk control block and closes its decision loop.
- Holds the spike feature vector currently being classified and accumulates bias + Σ coeff·feature from the control strobes (load_bias/add/mult/is_one/coeff/bias).
- Returns child_direction to the control block.
- Double-buffers incoming feature vectors and registers the final cluster result (level/path) when control reports out_valid.

Parameters:
FEATURES  3  features per spike vector; must match the control block
COEFF_BIT_DEPTH  4  signed coefficient width
BIAS_BIT_DEPTH  10  signed bias width
FEATURE_BIT_DEPTH  8  signed feature width
ACC_WIDTH  16  signed accumulator width; must be ≥ max(BIAS_BIT_DEPTH, FEATURE_BIT_DEPTH+COEFF_BIT_DEPTH) + $clog2(FEATURES+1)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
in_valid  in  1  feature vector offered
in_ready  out  1  pending slot free
in_features  in  FEATURES*FEATURE_BIT_DEPTH  feature 0 in MSBs, signed each
next  out  1  one-cycle pulse: new vector now active (to control)
load_bias  in  1  from control: first term of a node evaluation
add  in  1  from control: accumulate a term this cycle
mult  in  1  from control: term is coeff·feature
is_one  in  1  from control: term is feature (unit coefficient)
coeff  in  COEFF_BIT_DEPTH  signed coefficient
bias  in  BIAS_BIT_DEPTH  signed bias
child_direction  out  1  1 = sum ≥ 0 (right), 0 = sum < 0
ctl_level  in  $clog2(FEATURES)  final depth from control
ctl_path  in  $clog2(FEATURES)  path bits from control
ctl_out_valid  in  1  control classification done
cls_valid  out  1  one-cycle pulse: result registered
cls_level  out  $clog2(FEATURES)  registered final depth
cls_path  out  $clog2(FEATURES)  registered path
protocol_err  out  1  sticky error flag

Behaviour:
- Reset (reset=0, asynchronous): active and pending slots empty, acc=0, feat_idx=0, child_direction=0, next=0, cls_valid=0, cls_level=0, cls_path=0, protocol_err=0, in_ready=1 once reset is released. Reset mid-evaluation discards both slots.
- Buffering:
  - in_ready = pending slot empty. Accept on in_valid & in_ready into pending.
  - When active is empty and pending is full: pending moves to active in one cycle, pending clears, next pulses the following cycle.
  - A vector accepted while both slots are empty reaches active after 2 cycles (pending, then active). next pulses on cycle 3 relative to the accept edge.
- Feature index:
  - load_bias & add → feat_idx = 0.
  - Each add cycle uses feature[feat_idx], then feat_idx increments, saturating at FEATURES-1.
- Term per add cycle:
  - is_one=1 → sign-extended feature.
  - else mult=1 → signed coeff × feature.
  - else 0.
  - is_one takes priority over mult.
- Accumulator:
  - add & load_bias → acc ← sext(bias) + term.
  - add & ~load_bias → acc ← acc + term.
  - No saturation; two's-complement wrap at ACC_WIDTH.
  - add=0 → acc holds.
- child_direction:
  - On the FEATURES-th add cycle since load_bias (feat_idx == FEATURES-1), it is driven combinationally from the next accumulator value (~sign(acc_next)).
  - The same value is registered at that edge and held until the next final term.
  - Control may sample it in that cycle or any later cycle.
- Completion: on ctl_out_valid=1, cls_level/cls_path ← ctl_level/ctl_path, cls_valid pulses the next cycle, and the active slot empties.
- Simultaneous events:
  - Accept into pending and active-release on the same edge: both take effect, and the pending→active move happens the next cycle.
  - ctl_out_valid with active empty: result is still registered and protocol_err is set.
  - add with active empty: term forced to 0 and protocol_err is set.
- protocol_err clears only on reset.
- Latency:
  - child_direction is valid in the cycle of the last add.
  - cls_valid is 1 cycle after ctl_out_valid.

Test Plan:
1. Features (10,-3,5), bias -20, is_one on term 0, coeffs 2 and -1 on terms 1–2 → acc -21, child_direction=0 during third add cycle and held after.
2. Same features, bias +20 → acc 19, child_direction=1.
3. Features (4,0,0), bias -4, is_one term 0, mult=0 for the rest → acc 0, child_direction=1 (zero counts as right).
4. Back-to-back vectors: offer 3 vectors with no gaps while active busy → first to active, second to pending, in_ready=0 blocks third until ctl_out_valid; next pulses once per vector, in order.
5. ctl_out_valid with ctl_level=2, ctl_path=2'b10 → cls_valid one cycle later with cls_level=2, cls_path=2'b10; active freed.
6. Assert reset=0 mid-accumulation, after 2 terms → all outputs return to reset values immediately (asynchronous), in_ready=1 after release, and no cls_valid is emitted for the aborted vector.
